// File: rtl/cla_adder_pipe_pkg.sv
// rtl/cla_adder_pipe_pkg.sv - shared constants and parameter checks for the pipelined CLA adder
package cla_adder_pipe_pkg;

  // Width of one lookahead group
  localparam int GROUP_W = 4;

  // Operation select carried on the sub input
  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Legal configuration: at least one stage, and every stage gets a whole number of groups
  function automatic bit cla_params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= GROUP_W * stages) && ((width % (GROUP_W * stages)) == 0);
  endfunction

  // Groups per stage; falls back to 1 on an illegal configuration so elaboration
  // reaches the explicit error instead of dividing by zero
  function automatic int cla_gps(input int width, input int stages);
    return cla_params_ok(width, stages) ? (width / (GROUP_W * stages)) : 1;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit carry-lookahead group
module cla_group4
  import cla_adder_pipe_pkg::*;
(
  input  logic [GROUP_W-1:0] P,
  input  logic [GROUP_W-1:0] G,
  input  logic               cin,
  output logic [GROUP_W-1:0] S,
  output logic               cout,
  output logic               GP,
  output logic               GG
);

  // c[i] is the carry into bit i, each one flattened so no bit ripples through another
  logic [GROUP_W-1:0] c;

  assign c[0] = cin;
  assign c[1] = G[0] | (P[0] & cin);
  assign c[2] = G[1] | (P[1] & G[0]) | (P[1] & P[0] & cin);
  assign c[3] = G[2] | (P[2] & G[1]) | (P[2] & P[1] & G[0]) | (P[2] & P[1] & P[0] & cin);

  assign S = P ^ c;

  // Group propagate/generate let the next group take its carry without waiting on c[3]
  assign GP = &P;
  assign GG = G[3] | (P[3] & G[2]) | (P[3] & P[2] & G[1]) | (P[3] & P[2] & P[1] & G[0]);

  assign cout = GG | (GP & cin);

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_adder_pipe
  import cla_adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV,
  output logic             Z
);

  localparam int GPS  = cla_gps(WIDTH, STAGES);
  localparam int SW   = GPS * GROUP_W;
  localparam int LAST = STAGES - 1;

  if (!cla_params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("cla_adder_pipe: WIDTH must be a nonzero multiple of 4*STAGES and STAGES >= 1");
  end

  // Per-stage registers. a_q/b_q are the skew registers (operand bits not yet
  // consumed, with B already inverted for subtract); s_q is the alignment
  // register holding the sum bits finished so far; c_q is the inter-stage carry.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ov_q;
  logic              z_q;

  // Next-state values produced by each stage's combinational slice
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ov_d;
  logic              z_d;

  // Single global stall: everything moves together or nothing moves
  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_prev;
    logic             c_in;
    logic [SW-1:0]    s_slice;
    logic             gc   [GPS];
    logic             co_v [GPS];
    logic             gp_v [GPS];
    logic             gg_v [GPS];
    logic             sgp;
    logic             sgg;

    if (k == 0) begin : g_head
      // Subtract is resolved once here: invert B and force the carry-in
      assign a_in   = A;
      assign b_in   = (sub == SUB) ? ~B : B;
      assign c_in   = (sub == SUB) ? 1'b1 : cin;
      assign s_prev = '0;
    end else begin : g_body
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign c_in   = c_q[k-1];
      assign s_prev = s_q[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_group
      localparam int LSB = k * SW + j * GROUP_W;

      if (j == 0) begin : g_cin_first
        assign gc[j] = c_in;
      end else begin : g_cin_chain
        assign gc[j] = co_v[j-1];
      end

      cla_group4 u_group (
        .P    (a_in[LSB +: GROUP_W] ^ b_in[LSB +: GROUP_W]),
        .G    (a_in[LSB +: GROUP_W] & b_in[LSB +: GROUP_W]),
        .cin  (gc[j]),
        .S    (s_slice[j*GROUP_W +: GROUP_W]),
        .cout (co_v[j]),
        .GP   (gp_v[j]),
        .GG   (gg_v[j])
      );
    end

    // Stage-level propagate/generate, so the registered carry does not wait on the group chain
    always_comb begin
      sgp = 1'b1;
      sgg = 1'b0;
      for (int i = 0; i < GPS; i++) begin
        sgg = gg_v[i] | (gp_v[i] & sgg);
        sgp = sgp & gp_v[i];
      end
    end

    assign c_d[k] = sgg | (sgp & c_in);
    assign a_d[k] = a_in;
    assign b_d[k] = b_in;
    // Bits at and above this slice are still zero in s_prev, so OR-ing places the slice
    assign s_d[k] = s_prev | (WIDTH'(s_slice) << (k * SW));
  end

  // Flags use the last stage's operand sign bits, which rode along in the skew registers
  assign ov_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
  assign z_d  = (s_d[LAST] == '0);

  assign adv       = !v_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign S         = s_q[LAST];
  assign CO        = c_q[LAST];
  assign OV        = ov_q;
  assign Z         = z_q;

  // Pipeline registers: advance all stages on adv, hold otherwise; bubbles keep their slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q  <= '0;
      v_q  <= '0;
      ov_q <= 1'b0;
      z_q  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q  <= c_d;
      v_q  <= STAGES'({v_q, in_valid});
      ov_q <= ov_d;
      z_q  <= z_d;
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe
module tb_cla_adder_pipe;

  localparam int NSW = 5;
  localparam int NB  = 16;

  function automatic int sweep_w(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      2:       return 8;
      3:       return 32;
      default: return 32;
    endcase
  endfunction

  function automatic int sweep_s(input int i);
    case (i)
      0:       return 1;
      1:       return 1;
      2:       return 2;
      3:       return 1;
      default: return 8;
    endcase
  endfunction

  typedef struct {
    logic        sb;
    logic        ci;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] es;
    logic        eco;
    logic        eov;
    logic        ez;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        co;
  logic        ov;
  logic        z;

  int errors = 0;
  int checks = 0;
  int sweep_left = NSW;

  logic [15:0] st_a   [128];
  logic [15:0] st_b   [128];
  logic        st_sub [128];
  logic        st_cin [128];
  logic [18:0] st_exp [128];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .CO        (co),
    .OV        (ov),
    .Z         (z)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic sb, input logic c);
    logic [15:0] yy;
    logic [16:0] t;
    yy = sb ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {16'h0, (sb ? 1'b1 : c)};
    return {t[15:0], t[16], (x[15] == yy[15]) && (t[15] != x[15]), t[15:0] == 16'h0};
  endfunction

  function automatic logic [19:0] packv(input vec_t v);
    return {1'b1, v.es, v.eco, v.eov, v.ez};
  endfunction

  task automatic present(input vec_t v);
    in_valid = 1'b1;
    a        = v.va;
    b        = v.vb;
    sub      = v.sb;
    cin      = v.ci;
  endtask

  // Stream n beats back to back from st_* and check each result 2 cycles later
  task automatic run_stream(input int n, input string tag);
    for (int t = 0; t <= n; t++) begin
      if (t < n) begin
        in_valid = 1'b1;
        a        = st_a[t];
        b        = st_b[t];
        sub      = st_sub[t];
        cin      = st_cin[t];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (t == 0) chk({tag, "_latency"}, 64'(out_valid), 64'(0));
      else        chk(tag, 64'({out_valid, s, co, ov, z}), 64'({1'b1, st_exp[t-1]}));
      @(negedge clk);
    end
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t tbl [11];
    vec_t x0, x1, x2, x3;

    tbl[0]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};

    x0 = '{1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0};
    x1 = '{1'b1, 1'b0, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0, 1'b0};
    x2 = '{1'b0, 1'b0, 16'hF000, 16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1};
    x3 = '{1'b1, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({out_valid, s, co, ov, z}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    // Directed table, streamed back to back
    for (int i = 0; i < 11; i++) begin
      st_a[i]   = tbl[i].va;
      st_b[i]   = tbl[i].vb;
      st_sub[i] = tbl[i].sb;
      st_cin[i] = tbl[i].ci;
      st_exp[i] = {tbl[i].es, tbl[i].eco, tbl[i].eov, tbl[i].ez};
    end
    run_stream(11, "table");

    // 100 random beats against the reference model
    for (int i = 0; i < 100; i++) begin
      st_a[i]   = 16'($urandom);
      st_b[i]   = 16'($urandom);
      st_sub[i] = 1'($urandom);
      st_cin[i] = 1'($urandom);
      st_exp[i] = model16(st_a[i], st_b[i], st_sub[i], st_cin[i]);
    end
    run_stream(100, "random");

    // Backpressure with a full pipeline, then release with overlapping accept/consume
    flush();
    out_ready = 1'b0;
    present(x0);
    @(negedge clk);
    present(x1);
    @(negedge clk);
    present(x2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      chk("bp_hold", 64'({out_valid, s, co, ov, z}), 64'(packv(x0)));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    chk("bp_release_x0", 64'({out_valid, s, co, ov, z}), 64'(packv(x0)));
    @(negedge clk);
    chk("bp_x1", 64'({out_valid, s, co, ov, z}), 64'(packv(x1)));
    present(x3);
    #1;
    chk("bp_simul_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk("bp_x2", 64'({out_valid, s, co, ov, z}), 64'(packv(x2)));
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_x3", 64'({out_valid, s, co, ov, z}), 64'(packv(x3)));
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'(0));

    // Asynchronous reset with two beats in flight
    flush();
    present(tbl[0]);
    @(negedge clk);
    present(tbl[1]);
    @(negedge clk);
    chk("rst_pre_beat", 64'({out_valid, s, co, ov, z}), 64'(packv(tbl[0])));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({out_valid, s, co, ov, z}), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'(0));
    end
    st_a[0]   = tbl[2].va;
    st_b[0]   = tbl[2].vb;
    st_sub[0] = tbl[2].sb;
    st_cin[0] = tbl[2].ci;
    st_exp[0] = {tbl[2].es, tbl[2].eco, tbl[2].eov, tbl[2].ez};
    run_stream(1, "post_reset");

    for (int i = 0; i < 5000 && sweep_left != 0; i++) @(posedge clk);
    chk("sweep_done", 64'(sweep_left), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Parameter sweep: independent instances, each streaming random beats
  for (genvar gi = 0; gi < NSW; gi++) begin : g_sweep
    localparam int W  = sweep_w(gi);
    localparam int ST = sweep_s(gi);

    logic         rstn_l;
    logic         iv;
    logic         ir;
    logic [W-1:0] sa;
    logic [W-1:0] sbv;
    logic         ssub;
    logic         scin;
    logic         oval;
    logic         ordy;
    logic [W-1:0] ss;
    logic         sco;
    logic         sov;
    logic         sz;

    cla_adder_pipe #(.WIDTH(W), .STAGES(ST)) u_sweep (
      .clk       (clk),
      .rst_n     (rstn_l),
      .in_valid  (iv),
      .in_ready  (ir),
      .A         (sa),
      .B         (sbv),
      .sub       (ssub),
      .cin       (scin),
      .out_valid (oval),
      .out_ready (ordy),
      .S         (ss),
      .CO        (sco),
      .OV        (sov),
      .Z         (sz)
    );

    initial begin
      logic [W-1:0] va  [NB];
      logic [W-1:0] vb  [NB];
      logic         vs  [NB];
      logic         vc  [NB];
      logic [W-1:0] es  [NB];
      logic         eco [NB];
      logic         eov [NB];
      logic         ez  [NB];
      logic [W-1:0] bb;
      logic [W:0]   tmp;
      int           jj;
      string        nm;

      nm     = $sformatf("sweep_w%0d_s%0d", W, ST);
      rstn_l = 1'b0;
      iv     = 1'b0;
      ordy   = 1'b1;
      sa     = '0;
      sbv    = '0;
      ssub   = 1'b0;
      scin   = 1'b0;

      for (int i = 0; i < NB; i++) begin
        va[i]  = W'($urandom);
        vb[i]  = W'($urandom);
        vs[i]  = 1'($urandom);
        vc[i]  = 1'($urandom);
        bb     = vs[i] ? ~vb[i] : vb[i];
        tmp    = {1'b0, va[i]} + {1'b0, bb};
        tmp    = tmp + {{W{1'b0}}, (vs[i] ? 1'b1 : vc[i])};
        es[i]  = tmp[W-1:0];
        eco[i] = tmp[W];
        eov[i] = (va[i][W-1] == bb[W-1]) && (tmp[W-1] != va[i][W-1]);
        ez[i]  = (tmp[W-1:0] == '0);
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn_l = 1'b1;

      for (int t = 0; t < NB + ST - 1; t++) begin
        if (t < NB) begin
          iv   = 1'b1;
          sa   = va[t];
          sbv  = vb[t];
          ssub = vs[t];
          scin = vc[t];
        end else begin
          iv = 1'b0;
        end
        @(posedge clk);
        #1;
        jj = t - ST + 1;
        if (jj < 0) chk({nm, "_latency"}, 64'({ir, oval}), 64'({1'b1, 1'b0}));
        else        chk(nm, 64'({ir, oval, ss, sco, sov, sz}),
                        64'({1'b1, 1'b1, es[jj], eco[jj], eov[jj], ez[jj]}));
        @(negedge clk);
      end
      iv = 1'b0;
      sweep_left--;
    end
  end

endmodule
